// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder and imem loader: packs decoded fields into 32-bit
// words and streams them to consecutive instruction-memory word addresses.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LOAD  | accepting beats, one word written per accepted beat
// DONE  | last beat written, holding until start
// ERR   | offending beat rejected, err_code valid, holding until start
module instr_encoder_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_fmt,
    input  logic [6:0]        in_op,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic              full;
    logic              accept;
    logic              fmt_bad;
    logic              imm_bad;
    logic [31:0]       enc;

    assign accept  = in_valid && in_ready;
    assign fmt_bad = (in_fmt > 3'd5);

    // Immediate range check and field packing, both keyed on format.
    always_comb begin
        imm_bad = 1'b0;
        enc     = 32'd0;
        case (in_fmt)
            3'd0: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_op};
            3'd1: begin
                imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
                enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op};
            end
            3'd2: begin
                imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
                enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op};
            end
            3'd3: begin
                imm_bad = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
                enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_op};
            end
            3'd4: begin
                imm_bad = |in_imm[11:0];
                enc     = {in_imm[31:12], in_rd, in_op};
            end
            3'd5: begin
                imm_bad = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
                enc     = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op};
            end
            default: begin
                imm_bad = 1'b0;
                enc     = 32'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = S_LOAD;
        end else if (state == S_LOAD && accept) begin
            if (fmt_bad || full || imm_bad) state_nxt = S_ERR;
            else if (in_last)               state_nxt = S_DONE;
        end
    end

    always_comb begin
        busy     = (state == S_LOAD);
        done     = (state == S_DONE);
        err      = (state == S_ERR);
        in_ready = (state == S_LOAD) && !start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= BASE;
            full       <= 1'b0;
            count      <= '0;
            err_code   <= 2'd0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= 32'd0;
        end else if (start) begin
            ptr      <= BASE;
            full     <= 1'b0;
            count    <= '0;
            err_code <= 2'd0;
            imem_we  <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (accept) begin
                if (fmt_bad) begin
                    err_code <= 2'd1;
                end else if (full) begin
                    err_code <= 2'd3;
                end else if (imm_bad) begin
                    err_code <= 2'd2;
                end else begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ptr;
                    imem_wdata <= enc;
                    ptr        <= ptr + 1'b1;
                    count      <= count + 1'b1;
                    // Wrapped pointer must never be written: flag the top address.
                    full       <= (ptr == '1);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: vector table of single-beat sessions
// plus hand sequences for streaming, abort, overflow and async reset.
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [2:0]  in_fmt;
    logic [6:0]  in_op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, imem_we, busy, done, err;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [1:0]  err_code;
    logic [10:0] count;

    logic        b_in_ready, b_imem_we, b_busy, b_done, b_err;
    logic [1:0]  b_imem_addr;
    logic [31:0] b_imem_wdata;
    logic [1:0]  b_err_code;
    logic [2:0]  b_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(10), .BASE_ADDR(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .count(count)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_fmt(in_fmt), .in_op(in_op), .in_funct3(in_funct3), .in_funct7(in_funct7),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_last(in_last),
        .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .err_code(b_err_code), .count(b_count)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [1:0]  code;
        logic [31:0] word;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input logic last);
        in_valid = 1'b1; in_fmt = fmt; in_op = op; in_funct3 = f3; in_funct7 = f7;
        in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_last = last;
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    function automatic logic [31:0] dec_imm(input logic [2:0] fmt, input logic [31:0] w);
        case (fmt)
            3'd1:    return {{20{w[31]}}, w[31:20]};
            3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
            3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            3'd4:    return {w[31:12], 12'd0};
            3'd5:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        //         fmt   op     f3    f7     rd  rs1 rs2 imm           code  word
        vecs[0]  = '{3'd0, 7'h33, 3'd0, 7'h00, 3,  1,  2,  32'h00000000, 2'd0, 32'h002081B3};
        vecs[1]  = '{3'd1, 7'h13, 3'd0, 7'h00, 1,  0,  0,  32'hFFFFFFFF, 2'd0, 32'hFFF00093};
        vecs[2]  = '{3'd2, 7'h23, 3'd2, 7'h00, 0,  1,  2,  32'h00000008, 2'd0, 32'h0020A423};
        vecs[3]  = '{3'd3, 7'h63, 3'd0, 7'h00, 0,  0,  0,  32'hFFFFFFFC, 2'd0, 32'hFE000EE3};
        vecs[4]  = '{3'd5, 7'h6F, 3'd0, 7'h00, 1,  0,  0,  32'h00000800, 2'd0, 32'h001000EF};
        vecs[5]  = '{3'd4, 7'h37, 3'd0, 7'h00, 5,  0,  0,  32'h12345000, 2'd0, 32'h123452B7};
        vecs[6]  = '{3'd1, 7'h13, 3'd0, 7'h00, 1,  0,  0,  32'h00000800, 2'd2, 32'h0};
        vecs[7]  = '{3'd1, 7'h13, 3'd0, 7'h00, 1,  0,  0,  32'hFFFFF800, 2'd0, 32'h80000093};
        vecs[8]  = '{3'd3, 7'h63, 3'd0, 7'h00, 0,  0,  0,  32'h00000003, 2'd2, 32'h0};
        vecs[9]  = '{3'd3, 7'h63, 3'd0, 7'h00, 0,  0,  0,  32'h00001000, 2'd2, 32'h0};
        vecs[10] = '{3'd5, 7'h6F, 3'd0, 7'h00, 1,  0,  0,  32'h00100000, 2'd2, 32'h0};
        vecs[11] = '{3'd4, 7'h37, 3'd0, 7'h00, 5,  0,  0,  32'h00000800, 2'd2, 32'h0};
        vecs[12] = '{3'd0, 7'h33, 3'd0, 7'h20, 1,  2,  3,  32'h00012345, 2'd0, 32'h403100B3};
        vecs[13] = '{3'd6, 7'h33, 3'd0, 7'h00, 1,  2,  3,  32'h00000000, 2'd1, 32'h0};
        vecs[14] = '{3'd7, 7'h13, 3'd0, 7'h00, 1,  0,  0,  32'h00000801, 2'd1, 32'h0};
        vecs[15] = '{3'd3, 7'h63, 3'd0, 7'h00, 0,  0,  0,  32'h00000FFE, 2'd0, 32'h7E000FE3};
        vecs[16] = '{3'd5, 7'h6F, 3'd0, 7'h00, 0,  0,  0,  32'hFFFFFFFE, 2'd0, 32'hFFFFF06F};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = 0; in_op = 0; in_funct3 = 0; in_funct7 = 0;
        in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
        #12;
        chk("rst_we",    32'(imem_we),    0);
        chk("rst_addr",  32'(imem_addr),  4);
        chk("rst_wdata", imem_wdata,      0);
        chk("rst_count", 32'(count),      0);
        chk("rst_flags", {28'd0, busy, done, err, in_ready}, 0);
        chk("rst_code",  32'(err_code),   0);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready), 0);

        for (int i = 0; i < 17; i++) begin
            pulse_start();
            beat(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].rd,
                 vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1);
            tick();
            in_valid = 1'b0;
            if (vecs[i].code == 2'd0) begin
                chk($sformatf("v%0d_we", i),    32'(imem_we),   1);
                chk($sformatf("v%0d_wdata", i), imem_wdata,     vecs[i].word);
                chk($sformatf("v%0d_addr", i),  32'(imem_addr), 4);
                chk($sformatf("v%0d_count", i), 32'(count),     1);
                chk($sformatf("v%0d_done", i),  32'(done),      1);
                if (vecs[i].fmt != 3'd0)
                    chk($sformatf("v%0d_decode", i), dec_imm(vecs[i].fmt, imem_wdata), vecs[i].imm);
            end else begin
                chk($sformatf("v%0d_we", i),    32'(imem_we),  0);
                chk($sformatf("v%0d_err", i),   32'(err),      1);
                chk($sformatf("v%0d_code", i),  32'(err_code), 32'(vecs[i].code));
                chk($sformatf("v%0d_count", i), 32'(count),    0);
            end
        end

        // Back-to-back I, S, B with done on the third write.
        pulse_start();
        beat(3'd1, 7'h13, 3'd0, 7'h00, 1, 0, 0, 32'hFFFFFFFF, 1'b0);
        tick();
        chk("bb0_we", 32'(imem_we), 1); chk("bb0_addr", 32'(imem_addr), 4);
        chk("bb0_wdata", imem_wdata, 32'hFFF00093); chk("bb0_count", 32'(count), 1);
        chk("bb0_done", 32'(done), 0);
        beat(3'd2, 7'h23, 3'd2, 7'h00, 0, 1, 2, 32'h00000008, 1'b0);
        tick();
        chk("bb1_we", 32'(imem_we), 1); chk("bb1_addr", 32'(imem_addr), 5);
        chk("bb1_wdata", imem_wdata, 32'h0020A423); chk("bb1_count", 32'(count), 2);
        chk("bb1_done", 32'(done), 0);
        beat(3'd3, 7'h63, 3'd0, 7'h00, 0, 0, 0, 32'hFFFFFFFC, 1'b1);
        tick();
        chk("bb2_we", 32'(imem_we), 1); chk("bb2_addr", 32'(imem_addr), 6);
        chk("bb2_wdata", imem_wdata, 32'hFE000EE3); chk("bb2_count", 32'(count), 3);
        chk("bb2_done", 32'(done), 1); chk("bb2_busy", 32'(busy), 0);

        // DONE ignores further beats.
        beat(3'd0, 7'h33, 3'd0, 7'h00, 3, 1, 2, 32'h0, 1'b0);
        chk("done_ready", 32'(in_ready), 0);
        tick();
        chk("done_we", 32'(imem_we), 0); chk("done_hold", 32'(done), 1);
        chk("done_count", 32'(count), 3); chk("done_addr_hold", 32'(imem_addr), 6);
        in_valid = 1'b0;

        // Good word, then an out-of-range immediate; written word is kept.
        pulse_start();
        beat(3'd0, 7'h33, 3'd0, 7'h00, 3, 1, 2, 32'h0, 1'b0);
        tick();
        beat(3'd1, 7'h13, 3'd0, 7'h00, 1, 0, 0, 32'd2048, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("ek_we", 32'(imem_we), 0); chk("ek_err", 32'(err), 1);
        chk("ek_code", 32'(err_code), 2); chk("ek_count", 32'(count), 1);
        chk("ek_wdata_hold", imem_wdata, 32'h002081B3);
        pulse_start();
        chk("rs_busy", 32'(busy), 1); chk("rs_err", 32'(err), 0);
        chk("rs_code", 32'(err_code), 0); chk("rs_count", 32'(count), 0);

        // Abort mid-session; beat presented with start is not accepted.
        beat(3'd0, 7'h33, 3'd0, 7'h00, 3, 1, 2, 32'h0, 1'b0);
        tick();
        chk("ab_we0", 32'(imem_we), 1);
        start = 1'b1;
        #1;
        chk("ab_ready_start", 32'(in_ready), 0);
        chk("ab_inflight", 32'(imem_we), 1);
        tick();
        start = 1'b0;
        chk("ab_we1", 32'(imem_we), 0); chk("ab_count1", 32'(count), 0);
        chk("ab_busy", 32'(busy), 1);
        tick();
        in_valid = 1'b0;
        chk("ab_we2", 32'(imem_we), 1); chk("ab_addr2", 32'(imem_addr), 4);
        chk("ab_count2", 32'(count), 1);

        // Address overflow on the 2-bit instance.
        pulse_start();
        beat(3'd1, 7'h13, 3'd0, 7'h00, 1, 0, 0, 32'h0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk($sformatf("ov%0d_we", j),    32'(b_imem_we),   1);
            chk($sformatf("ov%0d_addr", j),  32'(b_imem_addr), j);
            chk($sformatf("ov%0d_count", j), 32'(b_count),     j + 1);
        end
        tick();
        in_valid = 1'b0;
        chk("ov4_we", 32'(b_imem_we), 0); chk("ov4_err", 32'(b_err), 1);
        chk("ov4_code", 32'(b_err_code), 3); chk("ov4_count", 32'(b_count), 4);
        chk("ov_main_busy", 32'(busy), 1);

        // Asynchronous reset with a write in flight.
        pulse_start();
        beat(3'd0, 7'h33, 3'd0, 7'h00, 3, 1, 2, 32'h0, 1'b0);
        tick();
        chk("ar_we_pre", 32'(imem_we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_we", 32'(imem_we), 0); chk("ar_addr", 32'(imem_addr), 4);
        chk("ar_wdata", imem_wdata, 0); chk("ar_count", 32'(count), 0);
        chk("ar_flags", {28'd0, busy, done, err, in_ready}, 0);
        chk("ar_b_count", 32'(b_count), 0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_idle", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Streaming RISC-V RV32I instruction encoder and instruction-memory loader: the inverse of the core's field/immediate decode path. It accepts one decoded instruction per handshake as format, opcode, funct3, funct7, register indices and a full 32-bit immediate. It range-checks the immediate, packs the 32-bit instruction word, and writes it to consecutive instruction-memory word addresses. It sits between a host/boot sequencer and the imem write port, and is used for program load and self-test.

## Interface
- ADDR_W, 10: imem word-address width.
- BASE_ADDR, 0: first word address written after `start`.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse. Starts or restarts a load session.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_op  in  7, in_funct3  in  3, in_funct7  in  7: opcode fields.
- in_rd, in_rs1, in_rs2  in  5 each: register indices.
- in_imm  in  32  full sign-extended immediate; a byte offset for B and J.
- in_last  in  1  marks the final beat of the session.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- busy  out  1  high in LOAD.
- done  out  1  high in DONE.
- err  out  1  high in ERR.
- err_code  out  2  0=none, 1=illegal format, 2=immediate out of range, 3=address overflow.
- count  out  ADDR_W+1  words written this session.

## Operation
- FSM states: IDLE, LOAD, DONE, ERR. Reset state is IDLE.
- `start` takes every state to LOAD. On that transition: write pointer = BASE_ADDR, count = 0, err_code = 0, full = 0.
- in_ready = (state == LOAD) && !start. A beat presented in a `start` cycle is not accepted.
- Accepted beat, checks applied in priority order:
  - in_fmt > 5: go to ERR, code 1.
  - full set: go to ERR, code 3.
  - immediate out of range: go to ERR, code 2.
  - Otherwise: write the word, pointer++, count++. full is set when the written address is all-ones. in_last moves the FSM to DONE.
- Immediate range rules (any violation gives code 2):
  - I, S: in_imm[31:11] all equal.
  - B: in_imm[31:12] all equal and in_imm[0] = 0.
  - J: in_imm[31:20] all equal and in_imm[0] = 0.
  - U: in_imm[11:0] = 0.
  - R: in_imm is ignored.
- Encoding, listed MSB to LSB:
  - R: funct7, rs2, rs1, funct3, rd, op.
  - I: imm[11:0], rs1, funct3, rd, op.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], op.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op.
  - U: imm[31:12], rd, op.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, op.
  - Fields a format does not use are ignored.
- An errored beat writes nothing. Words already written are kept.
- DONE and ERR hold, with in_ready = 0, until `start`.

## Timing
- Reset values: imem_we = 0, imem_addr = BASE_ADDR, imem_wdata = 0, count = 0, err_code = 0. busy, done, err and in_ready are all 0.
- Write latency is 1 cycle. A beat accepted at edge N drives imem_we, imem_addr and imem_wdata during cycle N+1. count is also updated in cycle N+1.
- imem_addr and imem_wdata hold their last values while imem_we = 0.
- Full throughput: one beat per cycle, no bubbles.
- For the last beat, done rises in the same cycle as its imem_we.
- err and err_code rise in the cycle after the offending beat is accepted.
- `start` during LOAD aborts the session. A write already registered from the previous edge still completes. Subsequent writes begin at BASE_ADDR.
- Pointer wrap: the address after all-ones is never written. The overflow beat gives code 3.
- rst_n asserted mid-session: all outputs return to reset values immediately and asynchronously. Any in-flight write is dropped.

## Test plan
- R-format beat, op=0x33, f3=0, f7=0, rd=3, rs1=1, rs2=2, after `start` -> imem_we=1 at BASE_ADDR next cycle, wdata 0x002081B3, count=1.
- Back-to-back beats: I (op=0x13, rd=1, imm=-1), then S (op=0x23, f3=2, rs1=1, rs2=2, imm=8), then B (op=0x63, imm=-4, in_last) -> wdata 0xFFF00093, 0x0020A423, 0xFE000EE3 at consecutive addresses on consecutive cycles. done rises with the third write.
- J beat, op=0x6F, rd=1, imm=0x800 -> wdata 0x001000EF. Feeding every format through the core decode path reproduces in_imm.
- I beat with imm=2048 -> no write, err=1, err_code=2. Then `start` -> state LOAD, err=0, count=0.
- With ADDR_W=2, five beats without in_last -> addresses 0..3 written, fifth beat gives err_code=3 with no write. Separately, in_fmt=6 gives err_code=1.
- rst_n pulsed low mid-stream, and `start` asserted together with in_valid -> outputs reset asynchronously; the beat presented with `start` is not accepted.
